// File: rtl/fmesh_route_stage.sv
// Registered XY / fully-adaptive route computation for one fmesh router input port,
// with a 2-entry skid buffer. Define FMESH_ROUTE_STAT_EN to add saturating beat/error counters.
module fmesh_route_stage #(
  parameter int    T1         = 4,
  parameter int    T2         = 4,
  parameter int    T3         = 1,
  parameter int    EAw        = 9,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    DSTPw      = 4,
  parameter int    PLw        = $clog2(4 + T3),
  localparam int   EXw        = $clog2(T1),
  localparam int   EYw        = $clog2(T2),
  localparam int   EPw        = EAw - EXw - EYw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXw-1:0]   current_x,
  input  logic [EYw-1:0]   current_y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EAw-1:0]   in_dest_e_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSTPw-1:0] out_dest_port_coded,
  output logic [PLw-1:0]   out_endp_localp_num,
  output logic [EAw-1:0]   out_dest_e_addr,
  output logic             out_addr_err
`ifdef FMESH_ROUTE_STAT_EN
  ,
  output logic [31:0]      stat_routed_cnt,
  output logic [31:0]      stat_err_cnt
`endif
);

  localparam bit ADAPTIVE = (ROUTE_TYPE == "FULL_ADAPTIVE");

  typedef struct packed {
    logic [DSTPw-1:0] coded;
    logic [PLw-1:0]   localp;
    logic [EAw-1:0]   addr;
    logic             err;
  } beat_t;

  logic [EXw-1:0] ex;
  logic [EYw-1:0] ey;
  logic [EPw-1:0] ep;
  logic           addr_ok;
  logic           east, north, dir_a, dir_b;
  beat_t          beat_new;

  // NOTE: every variable assigned in always_comb gets a default first so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    beat_new = '0;
    ex       = in_dest_e_addr[EXw-1:0];
    ey       = in_dest_e_addr[EXw +: EYw];
    ep       = in_dest_e_addr[EXw+EYw +: EPw];
    addr_ok  = (int'(ex) <= T1 - 1) && (int'(ey) <= T2 - 1) && (int'(ep) <= 3 + T3);
    east     = (ex > current_x);
    north    = (ey < current_y);
    dir_a    = (ex != current_x);
    dir_b    = (ey != current_y);
    // XY order: resolve x completely before y is considered.
    if (!ADAPTIVE && dir_a) dir_b = 1'b0;
    beat_new.addr = in_dest_e_addr;
    if (addr_ok) begin
      beat_new.coded  = {east, north, dir_a, dir_b};
      beat_new.localp = (!dir_a && !dir_b) ? PLw'(ep) : '0;
    end else begin
      beat_new.err    = 1'b1;
    end
  end

  logic  m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  beat_t m_data_q, m_data_d, s_data_q, s_data_d;
  logic  in_fire, out_fire;

  // Ready depends only on the skid slot, so it never combinationally follows out_ready.
  assign in_ready = ~s_valid_q & reset;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (!m_valid_q || out_ready) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = beat_new;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_data_d  = beat_new;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of process evaluation order.
  // NOTE: the data registers are reset as well, because the outputs must read 0
  // after reset rather than whatever the last beat left behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid           = m_valid_q;
  assign out_dest_port_coded = m_data_q.coded;
  assign out_endp_localp_num = m_data_q.localp;
  assign out_dest_e_addr     = m_data_q.addr;
  assign out_addr_err        = m_data_q.err;

`ifdef FMESH_ROUTE_STAT_EN
  logic [31:0] routed_cnt_q, routed_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    routed_cnt_d = routed_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (out_fire) begin
      if (routed_cnt_q != '1) routed_cnt_d = routed_cnt_q + 32'd1;
      if (m_data_q.err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      routed_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      routed_cnt_q <= routed_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign stat_routed_cnt = routed_cnt_q;
  assign stat_err_cnt    = err_cnt_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_fmesh_route_stage.sv
// Scoreboard bench for fmesh_route_stage: one XY and one fully-adaptive instance share stimulus,
// expected beats are queued at input handshake and compared at output handshake.
module tb_fmesh_route_stage;

  typedef struct {
    logic [3:0] coded;
    logic [2:0] lp;
    logic [8:0] addr;
    logic       err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] cur_x, cur_y;
  logic       in_valid;
  logic [8:0] in_dest_e_addr;
  logic       out_ready;

  logic       xy_in_ready, xy_out_valid, xy_err;
  logic [3:0] xy_coded;
  logic [2:0] xy_lp;
  logic [8:0] xy_addr;
  logic       fa_in_ready, fa_out_valid, fa_err;
  logic [3:0] fa_coded;
  logic [2:0] fa_lp;
  logic [8:0] fa_addr;
`ifdef FMESH_ROUTE_STAT_EN
  logic [31:0] xy_routed, xy_errcnt, fa_routed, fa_errcnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  exp_t q_xy[$];
  exp_t q_fa[$];
  exp_t e_xy, e_fa;

  fmesh_route_stage #(.T1(4), .T2(4), .T3(1), .EAw(9), .ROUTE_TYPE("DETERMINISTIC")) u_xy (
    .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
    .in_valid(in_valid), .in_ready(xy_in_ready), .in_dest_e_addr(in_dest_e_addr),
    .out_valid(xy_out_valid), .out_ready(out_ready), .out_dest_port_coded(xy_coded),
    .out_endp_localp_num(xy_lp), .out_dest_e_addr(xy_addr), .out_addr_err(xy_err)
`ifdef FMESH_ROUTE_STAT_EN
    , .stat_routed_cnt(xy_routed), .stat_err_cnt(xy_errcnt)
`endif
  );

  fmesh_route_stage #(.T1(4), .T2(4), .T3(1), .EAw(9), .ROUTE_TYPE("FULL_ADAPTIVE")) u_fa (
    .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
    .in_valid(in_valid), .in_ready(fa_in_ready), .in_dest_e_addr(in_dest_e_addr),
    .out_valid(fa_out_valid), .out_ready(out_ready), .out_dest_port_coded(fa_coded),
    .out_endp_localp_num(fa_lp), .out_dest_e_addr(fa_addr), .out_addr_err(fa_err)
`ifdef FMESH_ROUTE_STAT_EN
    , .stat_routed_cnt(fa_routed), .stat_err_cnt(fa_errcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input int ep, input int ey, input int ex);
    return {5'(ep), 2'(ey), 2'(ex)};
  endfunction

  // Reference route computation for a 4x4 mesh with one extra local port.
  function automatic exp_t model(input logic [8:0] a, input logic [1:0] cx, input logic [1:0] cy,
                                 input bit adaptive);
    exp_t r;
    logic [1:0] ex, ey;
    logic [4:0] ep;
    logic x_b, y_b, a_b, b_b;
    ex = a[1:0];
    ey = a[3:2];
    ep = a[8:4];
    r.addr = a;
    if (ep > 5'd4) begin
      r.coded = 4'b0000;
      r.lp    = 3'd0;
      r.err   = 1'b1;
    end else begin
      x_b = (ex > cx);
      y_b = (ey < cy);
      a_b = (ex != cx);
      b_b = (ey != cy) && (adaptive || !a_b);
      r.coded = {x_b, y_b, a_b, b_b};
      r.lp    = (!a_b && !b_b) ? ep[2:0] : 3'd0;
      r.err   = 1'b0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (xy_out_valid && out_ready) begin
        check("xy_sb_nonempty", 32'(q_xy.size() != 0), 32'd1);
        if (q_xy.size() != 0) begin
          e_xy = q_xy.pop_front();
          check("xy_coded", 32'(xy_coded), 32'(e_xy.coded));
          check("xy_localp", 32'(xy_lp), 32'(e_xy.lp));
          check("xy_addr", 32'(xy_addr), 32'(e_xy.addr));
          check("xy_err", 32'(xy_err), 32'(e_xy.err));
        end
      end
      if (fa_out_valid && out_ready) begin
        check("fa_sb_nonempty", 32'(q_fa.size() != 0), 32'd1);
        if (q_fa.size() != 0) begin
          e_fa = q_fa.pop_front();
          check("fa_coded", 32'(fa_coded), 32'(e_fa.coded));
          check("fa_localp", 32'(fa_lp), 32'(e_fa.lp));
          check("fa_addr", 32'(fa_addr), 32'(e_fa.addr));
          check("fa_err", 32'(fa_err), 32'(e_fa.err));
        end
      end
      if (in_valid && xy_in_ready) q_xy.push_back(model(in_dest_e_addr, cur_x, cur_y, 1'b0));
      if (in_valid && fa_in_ready) q_fa.push_back(model(in_dest_e_addr, cur_x, cur_y, 1'b1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds the beat until the edge that accepts it.
  task automatic send(input logic [8:0] a);
    int n;
    n = 0;
    in_dest_e_addr = a;
    in_valid       = 1'b1;
    @(negedge clk);
    while (!xy_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_accept_in_time", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_dest_e_addr = '0;
    out_ready      = 1'b1;
    cur_x          = 2'd1;
    cur_y          = 2'd2;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(xy_out_valid), 32'd0);
    check("rst_in_ready", 32'(xy_in_ready), 32'd0);
    check("rst_coded", 32'(xy_coded), 32'd0);
    check("rst_addr", 32'(xy_addr), 32'd0);
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(xy_in_ready), 32'd1);
    tick();

    // East, same row: XY goes x first.
    send(mk(0, 2, 3));
    check("east_valid", 32'(xy_out_valid), 32'd1);
    check("east_coded", 32'(xy_coded), 32'b1010);
    check("east_localp", 32'(xy_lp), 32'd0);
    check("east_err", 32'(xy_err), 32'd0);
    send(mk(0, 0, 1));
    check("north_coded", 32'(xy_coded), 32'b0101);
    send(mk(2, 2, 1));
    check("local_coded", 32'(xy_coded), 32'b0000);
    check("local_localp", 32'(xy_lp), 32'd2);

    send(mk(0, 3, 0));
    check("xy_diag_coded", 32'(xy_coded), 32'b0010);
    check("fa_diag_coded", 32'(fa_coded), 32'b0011);

    send(mk(7, 0, 3));
    check("bad_ep_coded", 32'(xy_coded), 32'b0000);
    check("bad_ep_localp", 32'(xy_lp), 32'd0);
    check("bad_ep_err", 32'(xy_err), 32'd1);
    check("bad_ep_addr", 32'(xy_addr), 32'(mk(7, 0, 3)));
    tick();
    check("bad_ep_drained", 32'(xy_out_valid), 32'd0);
`ifdef FMESH_ROUTE_STAT_EN
    check("stat_routed", xy_routed, 32'd5);
    check("stat_err", xy_errcnt, 32'd1);
`endif

    // Back-pressure: A fills main, B fills skid, C must wait.
    out_ready = 1'b0;
    send(mk(1, 1, 2));
    send(mk(0, 3, 3));
    in_dest_e_addr = mk(3, 2, 1);
    in_valid       = 1'b1;
    @(negedge clk);
    check("stall_in_ready", 32'(xy_in_ready), 32'd0);
    check("stall_hold_a", 32'(xy_addr), 32'(mk(1, 1, 2)));
    tick();
    @(negedge clk);
    check("stall_in_ready2", 32'(xy_in_ready), 32'd0);
    check("stall_hold_a2", 32'(xy_addr), 32'(mk(1, 1, 2)));
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_a", 32'(xy_addr), 32'(mk(1, 1, 2)));
    tick();
    @(negedge clk);
    check("drain_b", 32'(xy_addr), 32'(mk(0, 3, 3)));
    check("drain_b_ready", 32'(xy_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_c_valid", 32'(xy_out_valid), 32'd1);
    check("drain_c", 32'(xy_addr), 32'(mk(3, 2, 1)));
    tick();

    // Asynchronous reset with both registers full discards everything.
    out_ready = 1'b0;
    send(mk(0, 1, 1));
    send(mk(0, 2, 2));
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(xy_out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(xy_in_ready), 32'd0);
    check("mid_rst_addr", 32'(xy_addr), 32'd0);
    q_xy.delete();
    q_fa.delete();
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    send(mk(1, 0, 0));
    check("post_rst_valid", 32'(xy_out_valid), 32'd1);
    check("post_rst_addr", 32'(xy_addr), 32'(mk(1, 0, 0)));
    tick();
    check("post_rst_no_stale", 32'(xy_out_valid), 32'd0);

    // Mixed traffic from another router position, including invalid endpoints.
    cur_x = 2'd2;
    cur_y = 2'd1;
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 3 != 0);
      send(9'($urandom_range(0, 511)));
    end
    out_ready = 1'b1;
    n = 0;
    while ((q_xy.size() != 0 || q_fa.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("final_drain_in_time", 32'(n < 20), 32'd1);
    check("final_xy_empty", 32'(q_xy.size()), 32'd0);
    check("final_fa_empty", 32'(q_fa.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
